// File: rtl/char_scroller.sv
// char_scroller: captures up to four 2-bit character codes from a Load
// strobe and shows them on four active-low seven-segment digits. Once
// four characters are held, Rotate scrolls them left at one step per
// TICK_DIV clock cycles.
module char_scroller #(
    parameter int TICK_DIV = 50000000
) (
    input  logic       CLOCK_50,
    input  logic       Reset,
    input  logic [1:0] Char,
    input  logic       Load,
    input  logic       Rotate,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic       Full,
    output logic       Scrolling
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [2:0] CNT_FULL = 3'd4;
    localparam logic [1:0] CODE_BLANK = 2'b11;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        HOLD   = 2'd1,
        SCROLL = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    slot_q [4];
    logic [1:0]    slot_d [4];
    logic [2:0]    cnt_q, cnt_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          load_q, load_d;
    logic          cap_q, cap_d;
    logic          tick;

    // Code to active-low segment pattern, bit6=g ... bit0=a.
    function automatic logic [6:0] decode(input logic [1:0] code);
        case (code)
            2'b00:   decode = 7'b0100001;
            2'b01:   decode = 7'b0000110;
            2'b10:   decode = 7'b1111001;
            default: decode = 7'b1111111;
        endcase
    endfunction

    // Next-state logic: load edge detection, mode changes, prescaler and slot updates.
    always_comb begin
        load_d  = Load;
        cap_d   = Load & ~load_q;
        state_d = state_q;
        tick    = 1'b0;
        pre_d   = '0;
        cnt_d   = cnt_q;
        slot_d  = slot_q;

        case (state_q)
            FILL:    if (cnt_q == CNT_FULL) state_d = HOLD;
            HOLD:    if (Rotate) state_d = SCROLL;
            SCROLL:  if (!Rotate) state_d = HOLD;
            default: state_d = FILL;
        endcase

        if (state_q == SCROLL) begin
            tick = (pre_q == PRE_LAST);
        end

        // The prescaler only advances while staying in SCROLL, so it reads 0
        // on the first SCROLL cycle and whenever the block is not scrolling.
        if (state_q == SCROLL && state_d == SCROLL) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
        end

        // A capture takes priority over a coincident scroll step.
        if (cap_q) begin
            slot_d[3] = slot_q[2];
            slot_d[2] = slot_q[1];
            slot_d[1] = slot_q[0];
            slot_d[0] = Char;
            if (cnt_q != CNT_FULL) cnt_d = cnt_q + 3'd1;
        end else if (tick) begin
            slot_d[3] = slot_q[2];
            slot_d[2] = slot_q[1];
            slot_d[1] = slot_q[0];
            slot_d[0] = slot_q[3];
        end
    end

    // State registers with asynchronous clear to an empty, blank display.
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            state_q <= FILL;
            slot_q  <= '{CODE_BLANK, CODE_BLANK, CODE_BLANK, CODE_BLANK};
            cnt_q   <= '0;
            pre_q   <= '0;
            load_q  <= 1'b0;
            cap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            load_q  <= load_d;
            cap_q   <= cap_d;
        end
    end

    // Display and status outputs come straight from the registers.
    always_comb begin
        HEX0      = decode(slot_q[0]);
        HEX1      = decode(slot_q[1]);
        HEX2      = decode(slot_q[2]);
        HEX3      = decode(slot_q[3]);
        Full      = (cnt_q == CNT_FULL);
        Scrolling = (state_q == SCROLL);
    end

endmodule
